// File: rtl/uart_img_stream_engine.sv
// Image traffic engine for the UART inversion path: streams a host-loaded image
// into the tx side, captures and checks the returned rx words, and offers readback.
module uart_img_stream_engine #(
    parameter int DATA_W         = 8,
    parameter int IMG_BYTES      = 158,
    parameter int INVERT         = 1,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int IDX_W          = $clog2(IMG_BYTES + 1)
) (
    input  logic              clock,
    input  logic              reset_rtl,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    input  logic              i_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_data_valid,
    input  logic              i_tx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_data_valid,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [IDX_W:0]    o_err_count,
    output logic [IDX_W-1:0]  o_first_err_idx
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IMG_IDX  = IDX_W'(IMG_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_BYTES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [IDX_W:0]   ERR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [IDX_W-1:0]  load_ptr;
    logic [IDX_W-1:0]  tx_idx;
    logic [IDX_W-1:0]  rx_idx;
    logic [TO_W-1:0]   to_cnt;
    logic              tx_done_q;

    logic [DATA_W-1:0] img [IMG_BYTES];
    logic [DATA_W-1:0] res [IMG_BYTES];

    logic              tx_rise;
    logic              rx_active;
    logic              rx_in_range;
    logic              rx_write;
    logic              rx_mismatch;
    logic              rx_overflow;
    logic              timeout_hit;
    logic [DATA_W-1:0] img_rx;
    logic [DATA_W-1:0] exp_word;
    logic [IDX_W+1:0]  err_add;
    logic [IDX_W+1:0]  err_sum;
    logic [IDX_W:0]    err_next;
    logic [DATA_W-1:0] rd_word;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    assign tx_rise     = i_tx_done & ~tx_done_q;
    assign rx_active   = i_rx_data_valid &&
                         (state == S_SEND || state == S_WAIT_DONE || state == S_DRAIN);
    assign rx_in_range = (rx_idx < IMG_IDX);
    assign rx_write    = rx_active && rx_in_range;
    assign rx_overflow = rx_active && !rx_in_range;
    assign exp_word    = (INVERT != 0) ? ~img_rx : img_rx;
    assign rx_mismatch = rx_write && (i_rx_data != exp_word);
    assign timeout_hit = (state == S_DRAIN) && (rx_idx != IMG_IDX) &&
                         !i_rx_data_valid && (to_cnt == TO_LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        img_rx  = '0;
        rd_word = '0;
        err_add = '0;
        if (rx_in_range) img_rx = img[rx_idx];
        if (i_rd_addr < IMG_IDX) rd_word = res[i_rd_addr];
        if (rx_mismatch || rx_overflow) err_add = {{(IDX_W+1){1'b0}}, 1'b1};
        else if (timeout_hit)           err_add = {2'b00, IMG_IDX - rx_idx};
        err_sum  = {1'b0, o_err_count} + err_add;
        err_next = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[IDX_W:0];
    end

    // NOTE: image and result memories carry no reset; only their pointers do.
    always_ff @(posedge clock) begin
        if (o_load_ready && i_load_valid) img[load_ptr] <= i_load_data;
        if (rx_write)                     res[rx_idx]   <= i_rx_data;
    end

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) o_rd_data <= '0;
        else            o_rd_data <= rd_word;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen at the clock edge.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state           <= S_IDLE;
            load_ptr        <= '0;
            tx_idx          <= '0;
            rx_idx          <= '0;
            to_cnt          <= '0;
            tx_done_q       <= 1'b0;
            o_load_ready    <= 1'b1;
            o_tx_data       <= '0;
            o_tx_data_valid <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_timeout       <= 1'b0;
            o_err_count     <= '0;
            o_first_err_idx <= '1;
        end else begin
            tx_done_q       <= i_tx_done;
            o_tx_data_valid <= 1'b0;
            o_err_count     <= err_next;

            if (rx_write) begin
                rx_idx <= rx_idx + ONE_IDX;
                if (rx_mismatch && (o_first_err_idx == '1)) o_first_err_idx <= rx_idx;
            end
            if (rx_active) to_cnt <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_load_valid)
                        load_ptr <= (load_ptr == LAST_IDX) ? '0 : load_ptr + ONE_IDX;
                    if (i_start) begin
                        load_ptr        <= '0;
                        tx_idx          <= '0;
                        rx_idx          <= '0;
                        to_cnt          <= '0;
                        o_err_count     <= '0;
                        o_first_err_idx <= '1;
                        o_done          <= 1'b0;
                        o_timeout       <= 1'b0;
                        o_busy          <= 1'b1;
                        o_load_ready    <= 1'b0;
                        state           <= S_SEND;
                    end
                end
                S_SEND: begin
                    o_tx_data       <= img[tx_idx];
                    o_tx_data_valid <= 1'b1;
                    state           <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_rise) begin
                        tx_idx <= tx_idx + ONE_IDX;
                        state  <= (tx_idx == LAST_IDX) ? S_DRAIN : S_SEND;
                    end
                end
                S_DRAIN: begin
                    if (rx_idx == IMG_IDX || timeout_hit) begin
                        o_timeout    <= timeout_hit;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_load_ready <= 1'b1;
                        state        <= S_DONE;
                    end else if (!i_rx_data_valid) begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
